// File: rtl/ncc_pkg.sv
// Shared parameters, derived widths and FSM state type for the NCC best-match block.
package ncc_pkg;

    localparam int PIXEL_SIZE    = 8;
    localparam int LINE_SIZE     = 4;
    localparam int NUM_OF_LINES  = 4;
    localparam int NUM_TEMPLATES = 3;

    localparam int N       = LINE_SIZE * NUM_OF_LINES;
    localparam int ACC_W   = $clog2(NUM_OF_LINES) + $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
    localparam int SCORE_W = 2 * ACC_W + 1;
    localparam int VAR_W   = 2 * ACC_W;

    localparam int IDX_W  = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1;
    // template walker must also hold NUM_TEMPLATES to mark "all issued"
    localparam int K_W    = $clog2(NUM_TEMPLATES + 1);
    localparam int LCNT_W = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/ncc_score_calc.sv
// Covariance score for one template: N*SumTxI_k - SumI*T_sum_k, full width, signed.
module ncc_score_calc
    import ncc_pkg::*;
(
    input  logic [ACC_W-1:0]          SumI,
    input  logic [ACC_W-1:0]          SumTxI_k,
    input  logic [ACC_W-1:0]          T_sum_k,
    output logic signed [SCORE_W-1:0] score_k
);

    logic [SCORE_W-1:0] txi_x;
    logic [SCORE_W-1:0] si_x;
    logic [SCORE_W-1:0] ts_x;
    logic [SCORE_W-1:0] prod_n;
    logic [SCORE_W-1:0] prod_it;

    // operands are zero-extended first so neither product wraps; the
    // two's-complement difference is then the exact signed score
    assign txi_x   = SCORE_W'(SumTxI_k);
    assign si_x    = SCORE_W'(SumI);
    assign ts_x    = SCORE_W'(T_sum_k);
    assign prod_n  = SCORE_W'(N) * txi_x;
    assign prod_it = si_x * ts_x;
    assign score_k = $signed(prod_n - prod_it);

endmodule

// File: rtl/ncc_best_match.sv
// NCC best-match controller: counts accumulated lines, captures the frame sums,
// scores each template in turn through one shared score unit and reports the argmax.
//
// state   | meaning
// COLLECT | accepting line_valid, counting lines of the current frame
// SCAN    | walking templates through the score unit, tracking the best
// DONE    | result held on the outputs until result_ready
module ncc_best_match
    import ncc_pkg::*;
(
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      line_valid,
    output logic                      line_ready,
    input  logic [ACC_W-1:0]          Acc_lines_sum_I,
    input  logic [ACC_W-1:0]          Acc_lines_sum_I_square,
    input  logic [ACC_W-1:0]          Acc_lines_sum_T_x_I [NUM_TEMPLATES],
    input  logic [ACC_W-1:0]          T_sum [NUM_TEMPLATES],
    output logic                      acc_clear,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [IDX_W-1:0]          best_idx,
    output logic signed [SCORE_W-1:0] best_score,
    output logic [VAR_W-1:0]          var_I,
    output logic                      overrun
);

    state_e              state_q;
    logic [LCNT_W-1:0]   line_cnt_q;
    logic [K_W-1:0]      k_q;

    logic [ACC_W-1:0]    si_q;
    logic [ACC_W-1:0]    s2_q;
    logic [ACC_W-1:0]    txi_q [NUM_TEMPLATES];
    logic [ACC_W-1:0]    ts_q  [NUM_TEMPLATES];

    // one-deep score pipeline: keeps the 41-bit product off the compare path
    logic signed [SCORE_W-1:0] sc_q;
    logic [IDX_W-1:0]          sc_idx_q;
    logic                      sc_vld_q;

    logic [IDX_W-1:0]          k_sel;
    logic signed [SCORE_W-1:0] score_k;
    logic [VAR_W-1:0]          var_calc;

    assign line_ready = (state_q == COLLECT);
    assign k_sel      = (k_q < K_W'(NUM_TEMPLATES)) ? k_q[IDX_W-1:0] : '0;
    assign var_calc   = VAR_W'(N) * VAR_W'(s2_q) - VAR_W'(si_q) * VAR_W'(si_q);

    ncc_score_calc u_score (
        .SumI     (si_q),
        .SumTxI_k (txi_q[k_sel]),
        .T_sum_k  (ts_q[k_sel]),
        .score_k  (score_k)
    );

    // frame sequencing FSM with capture, score pipeline and registered outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= COLLECT;
            line_cnt_q   <= '0;
            k_q          <= '0;
            si_q         <= '0;
            s2_q         <= '0;
            for (int i = 0; i < NUM_TEMPLATES; i++) begin
                txi_q[i] <= '0;
                ts_q[i]  <= '0;
            end
            sc_q         <= '0;
            sc_idx_q     <= '0;
            sc_vld_q     <= 1'b0;
            acc_clear    <= 1'b0;
            result_valid <= 1'b0;
            best_idx     <= '0;
            best_score   <= '0;
            var_I        <= '0;
            overrun      <= 1'b0;
        end else begin
            acc_clear <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (line_valid) begin
                        if (line_cnt_q == LCNT_W'(NUM_OF_LINES - 1)) begin
                            si_q <= Acc_lines_sum_I;
                            s2_q <= Acc_lines_sum_I_square;
                            for (int i = 0; i < NUM_TEMPLATES; i++) begin
                                txi_q[i] <= Acc_lines_sum_T_x_I[i];
                                ts_q[i]  <= T_sum[i];
                            end
                            acc_clear  <= 1'b1;
                            line_cnt_q <= '0;
                            k_q        <= '0;
                            sc_vld_q   <= 1'b0;
                            state_q    <= SCAN;
                        end else begin
                            line_cnt_q <= line_cnt_q + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (line_valid) begin
                        overrun <= 1'b1;
                    end
                    if (k_q == '0) begin
                        var_I <= var_calc;
                    end
                    if (k_q < K_W'(NUM_TEMPLATES)) begin
                        sc_q     <= score_k;
                        sc_idx_q <= k_sel;
                        sc_vld_q <= 1'b1;
                        k_q      <= k_q + 1'b1;
                    end else begin
                        sc_vld_q <= 1'b0;
                    end
                    if (sc_vld_q) begin
                        // strict greater-than keeps the lower index on ties
                        if (sc_idx_q == '0 || sc_q > best_score) begin
                            best_idx   <= sc_idx_q;
                            best_score <= sc_q;
                        end
                        if (sc_idx_q == IDX_W'(NUM_TEMPLATES - 1)) begin
                            result_valid <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (line_valid) begin
                        overrun <= 1'b1;
                    end
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state_q      <= COLLECT;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ncc_best_match.sv
// Self-checking bench for ncc_best_match: directed vector table, backpressure,
// reset-mid-scan sequence and random frames against a plain-arithmetic model.
module tb_ncc_best_match;
    import ncc_pkg::*;

    typedef struct packed {
        logic [ACC_W-1:0]                    si;
        logic [ACC_W-1:0]                    s2;
        logic [NUM_TEMPLATES-1:0][ACC_W-1:0] ts;
        logic [NUM_TEMPLATES-1:0][ACC_W-1:0] txi;
    } frame_t;

    typedef struct {
        frame_t f;
        int     exp_idx;
        longint exp_score;
        longint exp_var;
        string  name;
    } vec_t;

    logic                      CLK = 1'b0;
    logic                      reset;
    logic                      line_valid;
    logic                      line_ready;
    logic [ACC_W-1:0]          si_in;
    logic [ACC_W-1:0]          s2_in;
    logic [ACC_W-1:0]          txi_in [NUM_TEMPLATES];
    logic [ACC_W-1:0]          ts_in  [NUM_TEMPLATES];
    logic                      acc_clear;
    logic                      result_valid;
    logic                      result_ready;
    logic [IDX_W-1:0]          best_idx;
    logic signed [SCORE_W-1:0] best_score;
    logic [VAR_W-1:0]          var_I;
    logic                      overrun;

    int n_chk   = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    bit exp_ovr = 1'b0;

    vec_t vecs [4];

    ncc_best_match dut (
        .CLK                    (CLK),
        .reset                  (reset),
        .line_valid             (line_valid),
        .line_ready             (line_ready),
        .Acc_lines_sum_I        (si_in),
        .Acc_lines_sum_I_square (s2_in),
        .Acc_lines_sum_T_x_I    (txi_in),
        .T_sum                  (ts_in),
        .acc_clear              (acc_clear),
        .result_valid           (result_valid),
        .result_ready           (result_ready),
        .best_idx               (best_idx),
        .best_score             (best_score),
        .var_I                  (var_I),
        .overrun                (overrun)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (acc_clear === 1'b1) acc_cnt++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic frame_t mk(input int si, input int s2,
                                  input int t0, input int t1, input int t2,
                                  input int x0, input int x1, input int x2);
        frame_t f;
        f.si     = ACC_W'(si);
        f.s2     = ACC_W'(s2);
        f.ts[0]  = ACC_W'(t0);
        f.ts[1]  = ACC_W'(t1);
        f.ts[2]  = ACC_W'(t2);
        f.txi[0] = ACC_W'(x0);
        f.txi[1] = ACC_W'(x1);
        f.txi[2] = ACC_W'(x2);
        return f;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        f.si = ACC_W'($urandom);
        f.s2 = ACC_W'($urandom);
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            f.ts[k]  = ACC_W'($urandom);
            f.txi[k] = ACC_W'($urandom);
        end
        return f;
    endfunction

    // reference: score every template, pick the first strict maximum
    function automatic void model(input frame_t f, output int idx,
                                  output longint sc, output longint v);
        longint s;
        idx = 0;
        sc  = 0;
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            s = longint'(N) * longint'(f.txi[k]) - longint'(f.si) * longint'(f.ts[k]);
            if (k == 0 || s > sc) begin
                sc  = s;
                idx = k;
            end
        end
        v = (longint'(N) * longint'(f.s2) - longint'(f.si) * longint'(f.si))
            & ((longint'(1) << VAR_W) - 1);
    endfunction

    task automatic apply(input frame_t f);
        si_in = f.si;
        s2_in = f.s2;
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            ts_in[k]  = f.ts[k];
            txi_in[k] = f.txi[k];
        end
    endtask

    task automatic pulse_lines(input int n);
        for (int i = 0; i < n; i++) begin
            line_valid = 1'b1;
            @(posedge CLK); #1;
            line_valid = 1'b0;
            if (i < n - 1) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic run_frame(input frame_t f, input int exp_idx, input longint exp_sc,
                             input longint exp_var, input int hold, input bit poke,
                             input bit lv_at_xfer, input string tag);
        int a0;
        int n;
        bit stable;
        apply(f);
        a0 = acc_cnt;
        pulse_lines(NUM_OF_LINES);
        chk({tag, " acc_clear_after_capture"}, longint'(acc_clear), 1);
        chk({tag, " line_ready_in_scan"}, longint'(line_ready), 0);
        apply(rnd_frame());
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, " latency"}, n, NUM_TEMPLATES + 1);
        chk({tag, " best_idx"}, longint'(best_idx), exp_idx);
        chk({tag, " best_score"}, longint'(best_score), exp_sc);
        chk({tag, " var_I"}, longint'(var_I), exp_var);
        chk({tag, " line_ready_in_done"}, longint'(line_ready), 0);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 3) line_valid = 1'b1;
            if (i == 5) apply(rnd_frame());
            @(posedge CLK); #1;
            line_valid = 1'b0;
            if (result_valid !== 1'b1 || longint'(best_idx) != exp_idx ||
                longint'(best_score) != exp_sc || longint'(var_I) != exp_var ||
                line_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) chk({tag, " hold_stable"}, longint'(stable), 1);
        if (poke) exp_ovr = 1'b1;
        chk({tag, " overrun_before_xfer"}, longint'(overrun), longint'(exp_ovr));
        result_ready = 1'b1;
        if (lv_at_xfer) line_valid = 1'b1;
        @(posedge CLK); #1;
        result_ready = 1'b0;
        line_valid   = 1'b0;
        if (lv_at_xfer) exp_ovr = 1'b1;
        chk({tag, " result_valid_after_xfer"}, longint'(result_valid), 0);
        chk({tag, " line_ready_after_xfer"}, longint'(line_ready), 1);
        chk({tag, " overrun_after_xfer"}, longint'(overrun), longint'(exp_ovr));
        chk({tag, " acc_clear_pulses"}, acc_cnt - a0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " line_ready"}, longint'(line_ready), 1);
        chk({tag, " result_valid"}, longint'(result_valid), 0);
        chk({tag, " acc_clear"}, longint'(acc_clear), 0);
        chk({tag, " best_idx"}, longint'(best_idx), 0);
        chk({tag, " best_score"}, longint'(best_score), 0);
        chk({tag, " var_I"}, longint'(var_I), 0);
        chk({tag, " overrun"}, longint'(overrun), 0);
    endtask

    initial begin
        int     m_idx;
        longint m_sc;
        longint m_var;
        bit     seen;
        frame_t f;

        vecs[0] = '{mk(160, 2000, 160, 160, 160, 1800, 2100, 1500), 1, 8000, 6400, "nominal"};
        vecs[1] = '{mk(160, 2000, 160, 160, 160, 2100, 2100, 1500), 0, 8000, 6400, "tie"};
        vecs[2] = '{mk(160, 2000, 160, 160, 160, 1500, 1400, 1550), 2, -800, 6400, "all_neg"};
        vecs[3] = '{mk(10, 50, 3, 7, 5, 4, 9, 20), 2, 270, 700, "small"};

        reset        = 1'b0;
        line_valid   = 1'b0;
        result_ready = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        check_reset_vals("por");
        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].f, vecs[i].exp_idx, vecs[i].exp_score, vecs[i].exp_var,
                      2, 1'b0, 1'b0, vecs[i].name);
        end

        // backpressure with a stray line in DONE and one on the transfer edge
        run_frame(vecs[0].f, 1, 8000, 6400, 10, 1'b1, 1'b1, "backpressure");

        for (int r = 0; r < 8; r++) begin
            f = rnd_frame();
            model(f, m_idx, m_sc, m_var);
            run_frame(f, m_idx, m_sc, m_var, $urandom_range(0, 3), 1'b0, 1'b0, "random");
        end

        // reset in the middle of SCAN discards the frame
        apply(vecs[0].f);
        pulse_lines(NUM_OF_LINES);
        @(posedge CLK); #2;
        reset = 1'b0;
        #1;
        check_reset_vals("mid_scan_reset");
        exp_ovr = 1'b0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (result_valid !== 1'b0) seen = 1'b1;
        end
        chk("no_stale_result", longint'(seen), 0);
        f = rnd_frame();
        model(f, m_idx, m_sc, m_var);
        run_frame(f, m_idx, m_sc, m_var, 1, 1'b0, 1'b0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ncc_best_match.md
NCC_BEST_MATCH -- requirements
Module: ncc_best_match

Interface
REQ-001 Parameters SHALL come from the shared parameters header: PIXEL_SIZE (8), LINE_SIZE (4), NUM_OF_LINES (4), NUM_TEMPLATES (3); derived N = LINE_SIZE*NUM_OF_LINES, ACC_W = $clog2(NUM_OF_LINES)+$clog2(LINE_SIZE)+2*PIXEL_SIZE, SCORE_W = 2*ACC_W+1.
REQ-002 CLK  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 line_valid  in  1  pulse: accumulators have absorbed one more line this cycle.
REQ-005 line_ready  out  1  high when block accepts line_valid.
REQ-006 Acc_lines_sum_I, Acc_lines_sum_I_square  in  ACC_W  accumulated image sums.
REQ-007 Acc_lines_sum_T_x_I[NUM_TEMPLATES]  in  ACC_W  accumulated template-image cross sums.
REQ-008 T_sum[NUM_TEMPLATES]  in  ACC_W  static per-template pixel sums, stable while block is not idle.
REQ-009 acc_clear  out  1  one-cycle pulse that clears the upstream accumulators.
REQ-010 result_valid  out  1 / result_ready  in  1  result handshake; transfer when both high.
REQ-011 best_idx  out  $clog2(NUM_TEMPLATES)  winning template index.
REQ-012 best_score  out  SCORE_W signed  winning covariance score.
REQ-013 var_I  out  2*ACC_W unsigned  image variance term.
REQ-014 overrun  out  1  sticky error flag.

Function
REQ-015 FSM states SHALL be COLLECT, SCAN, DONE; reset state COLLECT.
REQ-016 COLLECT: line_ready=1; each line_valid increments line counter (0..NUM_OF_LINES-1).
REQ-017 line_valid while counter = NUM_OF_LINES-1 SHALL, on the next edge, latch all input sums into capture registers, pulse acc_clear for exactly that cycle, reset the counter to 0, clear the template index, and enter SCAN.
REQ-018 SCAN SHALL process one template per cycle, index k = 0..NUM_TEMPLATES-1: score_k = N*SumTxI_k - SumI*T_sum_k, signed SCORE_W, no truncation.
REQ-019 Argmax SHALL use strict greater-than; ties keep the lower index; k=0 always loads as the initial best.
REQ-020 var_I SHALL equal N*SumI2 - SumI^2, computed from the captured values.
REQ-021 After the cycle processing k = NUM_TEMPLATES-1, the FSM SHALL enter DONE with result_valid=1.
REQ-022 Latency: the final line_valid at edge t causes acc_clear high in t..t+1, SCAN during t+1..t+NUM_TEMPLATES, and result_valid high from t+NUM_TEMPLATES+1.
REQ-023 DONE: best_idx, best_score and var_I SHALL hold stable until result_valid && result_ready; on the transfer edge, return to COLLECT and drop result_valid.
REQ-024 line_ready SHALL be 0 in SCAN and DONE; a line_valid there SHALL be ignored and SHALL set overrun, which stays set until reset.
REQ-025 line_valid in the same cycle as a DONE transfer SHALL be ignored and SHALL set overrun.
REQ-026 Scoring SHALL use only the captured values; input changes after capture SHALL NOT affect the result.

Reset
REQ-027 Reset assertion SHALL immediately force: state COLLECT, counter 0, k 0, acc_clear 0, result_valid 0, best_idx 0, best_score 0, var_I 0, overrun 0, line_ready 1 (from COLLECT).
REQ-028 Reset asserted mid-SCAN or mid-DONE SHALL discard the partial result; no result_valid follows.

Structure
REQ-029 Package ncc_pkg SHALL hold ACC_W, SCORE_W, N and the FSM state enum.
REQ-030 Score arithmetic SHALL live in sub-module ncc_score_calc: combinational, inputs SumI/SumTxI_k/T_sum_k, output score_k; the top instantiates it once, time-multiplexed by k.

Verification
REQ-031 Reset: assert reset low mid-run -> all outputs at REQ-027 values immediately.
REQ-032 Nominal: SumI=160, SumI2=2000, T_sum={160,160,160}, SumTxI={1800,2100,1500}, 4 line_valid pulses -> scores {3200,8000,-1600}, best_idx=1, best_score=8000, var_I=6400, result_valid 4 cycles after the last pulse, one acc_clear pulse.
REQ-033 Tie: SumTxI={2100,2100,1500} -> best_idx=0, best_score=8000.
REQ-034 All negative: SumTxI={1500,1400,1550} -> best_idx=2, best_score=-800.
REQ-035 Backpressure: result_ready low 10 cycles, line_valid pulsed in DONE -> outputs stable, line_ready=0, overrun=1; transfer when ready rises, then COLLECT.
REQ-036 Reset mid-SCAN, then a full frame -> no stale result_valid; a correct result for the new frame only.
